// File: rtl/keycode_pkg.sv
// rtl/keycode_pkg.sv - shared keycode constants, slot type and sizing helper
//
// Contents:
//   KC_W_BITS  width of one HID usage slot
//   kc_slot_t  one 8-bit keycode slot
//   KC_*       HID usage codes for the default W/A/S/D key set
//   idx_width  index width for N items, never less than 1
package keycode_pkg;

  localparam int KC_W_BITS = 8;

  typedef logic [KC_W_BITS-1:0] kc_slot_t;

  localparam kc_slot_t KC_NONE = 8'h00;
  localparam kc_slot_t KC_W    = 8'h1A;
  localparam kc_slot_t KC_A    = 8'h04;
  localparam kc_slot_t KC_S    = 8'h16;
  localparam kc_slot_t KC_D    = 8'h07;

  // A single key still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_repeat_ctr.sv
// rtl/key_repeat_ctr.sv - per-key frame-paced auto-repeat down-counter
//
// Only compiled when AUTO_REPEAT_EN is defined.
//
// Ports:
//   Clk           in   system clock
//   Reset         in   synchronous, active-high reset
//   pressed       in   key-down event, same cycle as the tracker's press register load
//   held          in   key currently matched (next-state of the tracker's held register)
//   frame_tick    in   one-cycle frame strobe
//   repeat_pulse  out  one-cycle auto-repeat pulse
`ifdef AUTO_REPEAT_EN
module key_repeat_ctr
  import keycode_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int REPEAT_DELAY = 15,
  parameter int REPEAT_RATE  = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic pressed,
  input  logic held,
  input  logic frame_tick,
  output logic repeat_pulse
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pulse_q;
  logic             pulse_d;

  // Priority: release clears, press reloads (so a coincident tick is
  // ignored), then ticks count down. A count of zero means idle.
  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (!held) begin
      cnt_d = '0;
    end else if (pressed) begin
      cnt_d = CNT_W'(REPEAT_DELAY);
    end else if (frame_tick && (cnt_q != '0)) begin
      if (cnt_q == CNT_W'(1)) begin
        cnt_d   = CNT_W'(REPEAT_RATE);
        pulse_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign repeat_pulse = pulse_q;

endmodule
`endif

// File: rtl/keycode_tracker.sv
// rtl/keycode_tracker.sv - HID keycode slots to per-key held/press/release/repeat state
//
// Optional feature macro: AUTO_REPEAT_EN (frame-paced auto-repeat pulses).
//
// Ports:
//   Clk           in   system clock
//   Reset         in   synchronous, active-high reset
//   keycode       in   NUM_SLOTS packed 8-bit HID codes, slot j = [8j+7:8j], 8'h00 empty
//   frame_tick    in   one-cycle frame strobe
//   held          out  key i currently down
//   pressed       out  one-cycle pulse on key-down
//   released      out  one-cycle pulse on key-up
//   repeat_pulse  out  one-cycle auto-repeat pulse (0 without AUTO_REPEAT_EN)
//   last_key      out  index of most recently pressed key
//   last_valid    out  last_key is meaningful
module keycode_tracker
  import keycode_pkg::*;
#(
  parameter int                            NUM_SLOTS    = 4,
  parameter int                            NUM_KEYS     = 4,
  parameter logic [NUM_KEYS*KC_W_BITS-1:0] KEY_CODES    = {KC_D, KC_S, KC_A, KC_W},
  parameter int                            REPEAT_DELAY = 15,
  parameter int                            REPEAT_RATE  = 4,
  parameter int                            CNT_W        = 8
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic [NUM_SLOTS*KC_W_BITS-1:0]    keycode,
  input  logic                              frame_tick,
  output logic [NUM_KEYS-1:0]               held,
  output logic [NUM_KEYS-1:0]               pressed,
  output logic [NUM_KEYS-1:0]               released,
  output logic [NUM_KEYS-1:0]               repeat_pulse,
  output logic [idx_width(NUM_KEYS)-1:0]    last_key,
  output logic                              last_valid
);

  localparam int LK_W = idx_width(NUM_KEYS);

  logic [NUM_SLOTS*KC_W_BITS-1:0] kc_q;
  logic [NUM_KEYS-1:0]            match;
  logic [NUM_KEYS-1:0]            held_q;
  logic [NUM_KEYS-1:0]            pressed_q;
  logic [NUM_KEYS-1:0]            pressed_d;
  logic [NUM_KEYS-1:0]            released_q;
  logic [NUM_KEYS-1:0]            released_d;
  logic [LK_W-1:0]                first_press;
  logic [LK_W-1:0]                last_key_q;
  logic [LK_W-1:0]                last_key_d;
  logic                           last_valid_q;
  logic                           last_valid_d;

  // A key matches if any slot carries its code; duplicates collapse into
  // one match, and a key configured as 8'h00 never matches an empty slot.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      for (int j = 0; j < NUM_SLOTS; j++) begin
        if ((kc_q[j*KC_W_BITS +: KC_W_BITS] == KEY_CODES[i*KC_W_BITS +: KC_W_BITS]) &&
            (KEY_CODES[i*KC_W_BITS +: KC_W_BITS] != KC_NONE)) begin
          match[i] = 1'b1;
        end
      end
    end
  end

  assign pressed_d  = match & ~held_q;
  assign released_d = ~match & held_q;

  // Scan downwards so the lowest simultaneous press wins.
  always_comb begin
    first_press = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pressed_d[i]) begin
        first_press = LK_W'(i);
      end
    end
  end

  // A new press always wins over a release in the same cycle. Releasing
  // the last key only drops the valid flag; the index is left as-is.
  always_comb begin
    last_key_d   = last_key_q;
    last_valid_d = last_valid_q;
    if (|pressed_d) begin
      last_key_d   = first_press;
      last_valid_d = 1'b1;
    end else if (last_valid_q && released_d[last_key_q]) begin
      last_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      kc_q         <= '0;
      held_q       <= '0;
      pressed_q    <= '0;
      released_q   <= '0;
      last_key_q   <= '0;
      last_valid_q <= 1'b0;
    end else begin
      kc_q         <= keycode;
      held_q       <= match;
      pressed_q    <= pressed_d;
      released_q   <= released_d;
      last_key_q   <= last_key_d;
      last_valid_q <= last_valid_d;
    end
  end

  assign held       = held_q;
  assign pressed    = pressed_q;
  assign released   = released_q;
  assign last_key   = last_key_q;
  assign last_valid = last_valid_q;

`ifdef AUTO_REPEAT_EN
  // Counters see the same press/held next-state as the output registers,
  // so the reload lands on the edge where pressed rises.
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_rep
    key_repeat_ctr #(
      .CNT_W        (CNT_W),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_rep (
      .Clk          (Clk),
      .Reset        (Reset),
      .pressed      (pressed_d[g]),
      .held         (match[g]),
      .frame_tick   (frame_tick),
      .repeat_pulse (repeat_pulse[g])
    );
  end
`else
  assign repeat_pulse = '0;

  logic [CNT_W-1:0] unused_cfg;
  assign unused_cfg = CNT_W'(REPEAT_DELAY) ^ CNT_W'(REPEAT_RATE) ^ {CNT_W{frame_tick}};
`endif

endmodule

// File: tb/tb_keycode_tracker.sv
// tb/tb_keycode_tracker.sv - self-checking bench for keycode_tracker
module tb_keycode_tracker;

`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] keycode;
  logic        frame_tick;
  logic [3:0]  held;
  logic [3:0]  pressed;
  logic [3:0]  released;
  logic [3:0]  repeat_pulse;
  logic [1:0]  last_key;
  logic        last_valid;

  int errors = 0;
  int checks = 0;

  // Entry i = bits [8i+7:8i]: 0=W(1A) 1=A(04) 2=S(16) 3=D(07)
  keycode_tracker #(
    .NUM_SLOTS    (4),
    .NUM_KEYS     (4),
    .KEY_CODES    (32'h0716041A),
    .REPEAT_DELAY (15),
    .REPEAT_RATE  (4),
    .CNT_W        (8)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .keycode      (keycode),
    .frame_tick   (frame_tick),
    .held         (held),
    .pressed      (pressed),
    .released     (released),
    .repeat_pulse (repeat_pulse),
    .last_key     (last_key),
    .last_valid   (last_valid)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] kc;
    logic [3:0]  h;
    logic [3:0]  p;
    logic [3:0]  r;
    logic [1:0]  lk;
    logic        lv;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] kc, input logic [3:0] h, input logic [3:0] p,
                     input logic [3:0] r, input logic [1:0] lk, input logic lv);
    vec_t v;
    v.kc = kc; v.h = h; v.p = p; v.r = r; v.lk = lk; v.lv = lv;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d actual=%0h expected=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm, input int idx);
    chk({nm, "_held"}, idx, 32'(held), 32'h0);
    chk({nm, "_pressed"}, idx, 32'(pressed), 32'h0);
    chk({nm, "_released"}, idx, 32'(released), 32'h0);
    chk({nm, "_repeat"}, idx, 32'(repeat_pulse), 32'h0);
    chk({nm, "_last_key"}, idx, 32'(last_key), 32'h0);
    chk({nm, "_last_valid"}, idx, 32'(last_valid), 32'h0);
  endtask

  // Holds one key with a tick every 10 cycles; the tick on the press edge
  // (cycle 1) must be ignored, first repeat after the 15th counted tick,
  // then every 4th. Afterwards releases the key and expects no repeats.
  task automatic repeat_run(input logic [31:0] kc, input int idx, input int ncyc);
    int         ticks;
    logic [3:0] e_rep;
    logic [3:0] e_p;
    logic [3:0] e_h;
    logic [3:0] e_r;
    ticks = 0;
    for (int c = 0; c < ncyc; c++) begin
      keycode    = kc;
      frame_tick = ((c % 10) == 1);
      step();
      if (frame_tick && c > 1) ticks++;
      e_rep = '0; e_p = '0; e_h = '0;
      e_rep[idx] = AR && frame_tick && (c > 1) && (ticks >= 15) && (((ticks - 15) % 4) == 0);
      e_p[idx]   = (c == 1);
      e_h[idx]   = (c >= 1);
      chk("rep_hold_repeat", c, 32'(repeat_pulse), 32'(e_rep));
      chk("rep_hold_pressed", c, 32'(pressed), 32'(e_p));
      chk("rep_hold_held", c, 32'(held), 32'(e_h));
    end
    for (int c = 0; c < 60; c++) begin
      keycode    = 32'h0;
      frame_tick = ((c % 10) == 5);
      step();
      e_h = '0; e_r = '0;
      e_h[idx] = (c == 0);
      e_r[idx] = (c == 1);
      chk("rep_rel_repeat", c, 32'(repeat_pulse), 32'h0);
      chk("rep_rel_held", c, 32'(held), 32'(e_h));
      chk("rep_rel_released", c, 32'(released), 32'(e_r));
    end
    frame_tick = 1'b0;
  endtask

  initial begin
    Reset      = 1'b1;
    keycode    = 32'h0000001A;
    frame_tick = 1'b0;

    // Reset with W already down: everything stays cleared.
    for (int i = 0; i < 2; i++) begin
      step();
      chk_all_zero("reset", i);
    end

    //   keycode        held     pressed  released lk  lv
    add(32'h0000001A, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    add(32'h0000001A, 4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b1);
    add(32'h0000001A, 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b1);
    add(32'h1A1A0000, 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b1);
    add(32'h00000000, 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b1);
    add(32'h00000000, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0);
    add(32'h00071604, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    add(32'h00071600, 4'b1110, 4'b1110, 4'b0000, 2'd1, 1'b1);
    add(32'h00071600, 4'b1100, 4'b0000, 4'b0010, 2'd1, 1'b0);
    add(32'h2C2C2C2C, 4'b1100, 4'b0000, 4'b0000, 2'd1, 1'b0);
    add(32'h2C2C2C2C, 4'b0000, 4'b0000, 4'b1100, 2'd1, 1'b0);
    add(32'h00000000, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0);
    add(32'h00000004, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0);
    add(32'h00000000, 4'b0010, 4'b0010, 4'b0000, 2'd1, 1'b1);
    add(32'h00000004, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b0);
    add(32'h00000004, 4'b0010, 4'b0010, 4'b0000, 2'd1, 1'b1);
    add(32'h00000007, 4'b0010, 4'b0000, 4'b0000, 2'd1, 1'b1);
    add(32'h0000161A, 4'b1000, 4'b1000, 4'b0010, 2'd3, 1'b1);
    add(32'h00000000, 4'b0101, 4'b0101, 4'b1000, 2'd0, 1'b1);
    add(32'h00000416, 4'b0000, 4'b0000, 4'b0101, 2'd0, 1'b0);
    add(32'h00000004, 4'b0110, 4'b0110, 4'b0000, 2'd1, 1'b1);
    add(32'h00000004, 4'b0010, 4'b0000, 4'b0100, 2'd1, 1'b1);
    add(32'h00000000, 4'b0010, 4'b0000, 4'b0000, 2'd1, 1'b1);
    add(32'h00000000, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b0);
    add(32'h00000000, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0);

    Reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      keycode = vecs[i].kc;
      step();
      chk("vec_held", i, 32'(held), 32'(vecs[i].h));
      chk("vec_pressed", i, 32'(pressed), 32'(vecs[i].p));
      chk("vec_released", i, 32'(released), 32'(vecs[i].r));
      chk("vec_repeat", i, 32'(repeat_pulse), 32'h0);
      chk("vec_last_key", i, 32'(last_key), 32'(vecs[i].lk));
      chk("vec_last_valid", i, 32'(last_valid), 32'(vecs[i].lv));
    end

    // W held with periodic ticks, then release.
    repeat_run(32'h0000001A, 0, 260);

    // D held with the counter mid-count, then Reset while still held.
    for (int c = 0; c < 80; c++) begin
      keycode    = 32'h00000007;
      frame_tick = ((c % 10) == 1);
      step();
    end
    chk("mid_held", 0, 32'(held), 32'h8);
    Reset      = 1'b1;
    frame_tick = 1'b1;
    step();
    chk_all_zero("mid_reset", 0);
    Reset      = 1'b0;
    frame_tick = 1'b0;
    // pressed re-fires on the second edge and the delay restarts at 15 ticks.
    repeat_run(32'h00000007, 3, 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
